push_button_debouncer: RTL and testbench
========================================

Name: push_button_debouncer

Overview:
- Front-end for the four board push buttons (Previous, Next, Okay, Cancel) that feed the menu/cursor adapter.
- Synchronises the raw pin levels, debounces them and emits clean single-cycle press pulses.
- Generates auto-repeat pulses for Previous/Next while held, so the cursor scrolls on a long press.
- Output oButton connects directly to the adapter's button_state input. Bit map: [0] Previous, [1] Next, [2] Okay, [3] Cancel.

Parameters:
N_BTN, 4, number of button channels
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz)
HOLD_CYCLES, 25000000, cycles a press must stay held (after the first pulse) before auto-repeat starts (500 ms)
REPEAT_CYCLES, 5000000, period between auto-repeat pulses (100 ms)
REPEAT_MASK, 4'b0011, per-button auto-repeat enable

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; low forces idle
iButton  input  N_BTN  raw asynchronous button pins
oButton  output  N_BTN  one-cycle press/repeat pulses, registered
oLevel  output  N_BTN  debounced level, 1 = pressed, registered

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the only clock. All synchroniser flops load the released level. Counters = 0, every channel FSM = RELEASED, oButton = 0, oLevel = 0.
- Synchroniser: two flops per bit. The sample is inverted when ACTIVE_LOW = 1, giving p = 1 for pressed.
- Channel FSM states:
  - RELEASED: cnt = 0. If p = 1, go to PRESS_CHK with cnt = 1.
  - PRESS_CHK: if p = 0, go to RELEASED with cnt = 0. Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, pulse oButton for 1 cycle, set oLevel = 1, cnt = 0, and go to HELD.
  - HELD: if p = 0, go to RELEASE_CHK. Else if REPEAT_MASK bit = 1, cnt++; when cnt reaches HOLD_CYCLES, pulse, cnt = 0, go to REPEATING. If the mask bit = 0, cnt stays 0.
  - REPEATING: if p = 0, go to RELEASE_CHK. Else cnt++; when cnt reaches REPEAT_CYCLES, pulse and cnt = 0.
  - RELEASE_CHK: if p = 1, return to HELD with cnt = 0 (no new pulse; a bounce never re-triggers). Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES, set oLevel = 0 and go to RELEASED.
- Latency: if p first reads pressed at edge k and stays stable, oButton is high for exactly the cycle after edge k + DEBOUNCE_CYCLES - 1. This is 2 + DEBOUNCE_CYCLES cycles from the raw pin edge.
- Pulse width: always exactly 1 clk. The repeat period is exactly REPEAT_CYCLES clks between rising pulses. The first repeat follows the initial pulse by HOLD_CYCLES clks.
- Channel independence: channels are fully independent. Several oButton bits may assert in the same cycle; arbitration belongs downstream.
- Counter: one per channel, width $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1). It saturates; it never wraps.
- en = 0 (synchronous): FSMs go to RELEASED, counters = 0, oButton = 0, oLevel = 0. The synchroniser keeps running.
- en rising with a button already held: a full debounce is required, then exactly one pulse is emitted. This is intended (a held key counts as a fresh press).
- Reset asserted mid-count: immediate return to reset values. No pulse is emitted on reset release unless a full debounce completes.

Decomposition:
- Shared package/header: button index constants BTN_PREV = 0, BTN_NEXT = 1, BTN_OK = 2, BTN_CANCEL = 3; channel state encodings; default timing constants for 50 MHz.
- Sub-module push_button_channel: one synchroniser, FSM and counter, instantiated N_BTN times in a generate loop. Its repeat enable is a per-instance parameter taken from REPEAT_MASK.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES = 8, HOLD_CYCLES = 32, REPEAT_CYCLES = 16.
- Clean press: iButton[2] driven low for 100 cycles -> one oButton[2] pulse 10 cycles after the pin edge; oLevel[2] = 1; no further pulses (Okay is not in REPEAT_MASK). Release -> oLevel[2] = 0 ten cycles after the release edge.
- Bounce: iButton[0] toggles every 3 cycles for 40 cycles, then held low -> no pulse during the bounce; exactly one pulse 10 cycles after the last edge.
- Auto-repeat: iButton[1] held low for 120 cycles -> pulses at +10, +42, +58, +74, +90, +106 relative to the pin edge; stop on release.
- Release bounce: while button 0 is held, pin glitches high for 4 cycles -> no extra pulse; oLevel[0] stays 1.
- Simultaneous press: iButton[0] and iButton[3] fall on the same edge -> oButton = 4'b1001 in a single cycle.
- Enable/reset: en dropped mid PRESS_CHK -> outputs 0 and no pulse; rst_n pulsed low during REPEATING -> outputs 0 immediately; after release of reset, a held pin yields one pulse after a full debounce.

Source files
------------

// File: rtl/push_button_debouncer_pkg.sv
// Shared definitions for the push-button front-end: button indices,
// channel state encodings and default 50 MHz timing.
package push_button_debouncer_pkg;

    localparam int BTN_PREV   = 0;
    localparam int BTN_NEXT   = 1;
    localparam int BTN_OK     = 2;
    localparam int BTN_CANCEL = 3;

    localparam int DEF_N_BTN           = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_HOLD_CYCLES     = 25_000_000;
    localparam int DEF_REPEAT_CYCLES   = 5_000_000;

    // Only the cursor-movement buttons scroll on a long press.
    localparam logic [3:0] DEF_REPEAT_MASK = (4'b1 << BTN_PREV) | (4'b1 << BTN_NEXT);

    typedef enum logic [2:0] {
        ST_RELEASED    = 3'd0,
        ST_PRESS_CHK   = 3'd1,
        ST_HELD        = 3'd2,
        ST_REPEATING   = 3'd3,
        ST_RELEASE_CHK = 3'd4
    } chan_state_e;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/push_button_channel.sv
// One button channel: two-flop synchroniser, debounce/auto-repeat FSM
// and a shared saturating counter. Outputs are registered.
module push_button_channel
    import push_button_debouncer_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic btn_raw_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int CNT_MAX = maxOf3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Each terminal value is one less than the cycle count because the
    // transition out of the state happens on the edge the count would reach it.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic          IDLE_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed;
    chan_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          pulse_q;
    logic          level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ IDLE_LVL;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else if (!en) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    cnt_q <= '0;
                    if (pressed) begin
                        state_q <= ST_PRESS_CHK;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_PRESS_CHK: begin
                    if (!pressed) begin
                        state_q <= ST_RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!pressed) begin
                        state_q <= ST_RELEASE_CHK;
                        cnt_q   <= CW'(1);
                    end else if (!REPEAT_EN) begin
                        cnt_q <= '0;
                    end else if (cnt_q >= HOLD_LAST) begin
                        state_q <= ST_REPEATING;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_REPEATING: begin
                    if (!pressed) begin
                        state_q <= ST_RELEASE_CHK;
                        cnt_q   <= CW'(1);
                    end else if (cnt_q >= REP_LAST) begin
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_RELEASE_CHK: begin
                    // A bounce back to pressed resumes the hold without a new pulse.
                    if (pressed) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q <= ST_RELEASED;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_RELEASED;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/push_button_debouncer.sv
// Four-button front-end for the menu/cursor adapter: per-channel debounce,
// single-cycle press pulses and auto-repeat on the masked buttons.
module push_button_debouncer
    import push_button_debouncer_pkg::*;
#(
    parameter int               N_BTN           = DEF_N_BTN,
    parameter bit               ACTIVE_LOW      = 1'b1,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int               HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int               REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_BTN-1:0] iButton,
    output logic [N_BTN-1:0] oButton,
    output logic [N_BTN-1:0] oLevel
);

    for (genvar i = 0; i < N_BTN; i++) begin : gChannel
        push_button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) uChannel (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .btn_raw_i (iButton[i]),
            .pulse_o   (oButton[i]),
            .level_o   (oLevel[i])
        );
    end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with short timing constants
// (debounce 8, hold 32, repeat 16); pins are active-low.
module tb_push_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] iButton;
    logic [3:0] oButton;
    logic [3:0] oLevel;

    int compCount = 0;
    int errCount  = 0;

    push_button_debouncer #(
        .N_BTN           (4),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (32),
        .REPEAT_CYCLES   (16),
        .REPEAT_MASK     (4'b0011)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .iButton (iButton),
        .oButton (oButton),
        .oLevel  (oLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] pins);
        iButton = pins;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compCount++;
        assert (obs === exp)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCycle(input string tag, input int t, input logic [3:0] expBtn,
                              input logic [3:0] expLvl);
        checkOutput($sformatf("%s.btn@%0d", tag, t), oButton, expBtn);
        checkOutput($sformatf("%s.lvl@%0d", tag, t), oLevel, expLvl);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] eb;
        logic [3:0] el;

        rst_n = 1'b0;
        en    = 1'b1;
        applyStimulus(4'b1111);
        tick();
        tick();
        checkCycle("reset", 0, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checkCycle("idle", t, 4'b0000, 4'b0000);
        end

        // Clean press on Okay: one pulse at +10, no repeat.
        applyStimulus(4'b1011);
        for (int t = 1; t <= 100; t++) begin
            tick();
            eb = (t == 10) ? 4'b0100 : 4'b0000;
            el = (t >= 10) ? 4'b0100 : 4'b0000;
            checkCycle("okPress", t, eb, el);
        end
        applyStimulus(4'b1111);
        for (int t = 1; t <= 14; t++) begin
            tick();
            el = (t < 10) ? 4'b0100 : 4'b0000;
            checkCycle("okRelease", t, 4'b0000, el);
        end

        // Bouncing Previous: 3-cycle segments never pass debounce.
        for (int t = 0; t < 40; t++) begin
            applyStimulus(((t / 3) % 2 == 0) ? 4'b1110 : 4'b1111);
            tick();
            checkCycle("bounce", t, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b1110);
        for (int t = 1; t <= 20; t++) begin
            tick();
            eb = (t == 10) ? 4'b0001 : 4'b0000;
            el = (t >= 10) ? 4'b0001 : 4'b0000;
            checkCycle("bounceSettle", t, eb, el);
        end

        // Short release glitch while held: no pulse, level stays up.
        applyStimulus(4'b1111);
        for (int t = 1; t <= 4; t++) begin
            tick();
            checkCycle("glitch", t, 4'b0000, 4'b0001);
        end
        applyStimulus(4'b1110);
        for (int t = 1; t <= 24; t++) begin
            tick();
            checkCycle("glitchAfter", t, 4'b0000, 4'b0001);
        end
        applyStimulus(4'b1111);
        for (int t = 1; t <= 12; t++) begin
            tick();
            el = (t < 10) ? 4'b0001 : 4'b0000;
            checkCycle("prevRelease", t, 4'b0000, el);
        end

        // Auto-repeat on Next: +10, then +42, then every 16.
        applyStimulus(4'b1101);
        for (int t = 1; t <= 116; t++) begin
            tick();
            eb = (t == 10 || t == 42 || t == 58 || t == 74 || t == 90 || t == 106)
                 ? 4'b0010 : 4'b0000;
            el = (t >= 10) ? 4'b0010 : 4'b0000;
            checkCycle("repeat", t, eb, el);
        end
        applyStimulus(4'b1111);
        for (int t = 1; t <= 20; t++) begin
            tick();
            el = (t < 10) ? 4'b0010 : 4'b0000;
            checkCycle("repeatStop", t, 4'b0000, el);
        end

        // Previous and Cancel fall together.
        applyStimulus(4'b0110);
        for (int t = 1; t <= 12; t++) begin
            tick();
            eb = (t == 10) ? 4'b1001 : 4'b0000;
            el = (t >= 10) ? 4'b1001 : 4'b0000;
            checkCycle("simul", t, eb, el);
        end
        applyStimulus(4'b1111);
        for (int t = 1; t <= 12; t++) begin
            tick();
            el = (t < 10) ? 4'b1001 : 4'b0000;
            checkCycle("simulRelease", t, 4'b0000, el);
        end

        // Enable dropped mid-debounce aborts; re-enable with pin held needs full debounce.
        applyStimulus(4'b1011);
        for (int t = 1; t <= 5; t++) begin
            tick();
            checkCycle("enPre", t, 4'b0000, 4'b0000);
        end
        en = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            checkCycle("enLow", t, 4'b0000, 4'b0000);
        end
        en = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            eb = (t == 8) ? 4'b0100 : 4'b0000;
            el = (t >= 8) ? 4'b0100 : 4'b0000;
            checkCycle("enRise", t, eb, el);
        end
        applyStimulus(4'b1111);
        for (int t = 1; t <= 12; t++) begin
            tick();
            el = (t < 10) ? 4'b0100 : 4'b0000;
            checkCycle("enRelease", t, 4'b0000, el);
        end

        // Async reset while Next is repeating; held pin re-debounces afterwards.
        applyStimulus(4'b1101);
        for (int t = 1; t <= 50; t++) begin
            tick();
            eb = (t == 10 || t == 42) ? 4'b0010 : 4'b0000;
            el = (t >= 10) ? 4'b0010 : 4'b0000;
            checkCycle("preReset", t, eb, el);
        end
        rst_n = 1'b0;
        #1;
        checkCycle("asyncReset", 0, 4'b0000, 4'b0000);
        tick();
        tick();
        checkCycle("inReset", 0, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            eb = (t == 10) ? 4'b0010 : 4'b0000;
            el = (t >= 10) ? 4'b0010 : 4'b0000;
            checkCycle("postReset", t, eb, el);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
